// File: rtl/vram_pkg.sv
// Shared video RAM definitions used by the arbiter, the RAM wrapper and scanout.
// Widths, read latency and the read-owner encoding live here.
package vram_pkg;

    localparam int VRAM_AW         = 15;
    localparam int VRAM_DW         = 8;
    localparam int VRAM_RD_LATENCY = 2;

    localparam logic OWN_VID = 1'b0;
    localparam logic OWN_CPU = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/vram_rd_tracker.sv
// Follows each issued RAM read through the RAM latency and steers the returning
// byte to the port that asked for it; return data is held between returns.
module vram_rd_tracker
    import vram_pkg::*;
#(
    parameter int LATENCY = VRAM_RD_LATENCY
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               issue_valid,
    input  logic               issue_owner,
    input  logic [VRAM_DW-1:0] ram_rdata,
    output logic               vid_rvalid,
    output logic [VRAM_DW-1:0] vid_rdata,
    output logic               cpu_rvalid,
    output logic [VRAM_DW-1:0] cpu_rdata
);

    rd_tag_t            tag_q [LATENCY];
    rd_tag_t            tag_d [LATENCY];
    rd_tag_t            ret_tag;
    logic [VRAM_DW-1:0] vid_data_q, vid_data_d;
    logic [VRAM_DW-1:0] cpu_data_q, cpu_data_d;

    always_comb begin
        tag_d[0] = '{valid: issue_valid, owner: issue_owner};
        for (int i = 1; i < LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        ret_tag = tag_q[LATENCY-1];

        vid_rvalid = ret_tag.valid && (ret_tag.owner == OWN_VID);
        cpu_rvalid = ret_tag.valid && (ret_tag.owner == OWN_CPU);

        // ram_rdata is already a RAM output register, so the returning byte is
        // passed through on its own cycle and captured for the hold afterwards.
        vid_data_d = vid_rvalid ? ram_rdata : vid_data_q;
        cpu_data_d = cpu_rvalid ? ram_rdata : cpu_data_q;
        vid_rdata  = vid_data_d;
        cpu_rdata  = cpu_data_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
            vid_data_q <= '0;
            cpu_data_q <= '0;
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
            vid_data_q <= vid_data_d;
            cpu_data_q <= cpu_data_d;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: video has priority, but after MAX_VID_RUN
// consecutive video grants against a waiting CPU the CPU takes the next slot.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int MAX_VID_RUN = 7,
    parameter int RAM_LATENCY = VRAM_RD_LATENCY
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               vid_req,
    input  logic [VRAM_AW-1:0] vid_addr,
    output logic               vid_gnt,
    output logic               vid_rvalid,
    output logic [VRAM_DW-1:0] vid_rdata,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [VRAM_AW-1:0] cpu_addr,
    input  logic [VRAM_DW-1:0] cpu_wdata,
    output logic               cpu_gnt,
    output logic               cpu_rvalid,
    output logic [VRAM_DW-1:0] cpu_rdata,
    output logic [VRAM_AW-1:0] ram_addr,
    output logic               ram_we,
    output logic [VRAM_DW-1:0] ram_wdata,
    input  logic [VRAM_DW-1:0] ram_rdata
);

    localparam logic [3:0] RUN_LIMIT = 4'(MAX_VID_RUN);

    logic [3:0] run_cnt_q, run_cnt_d;
    logic       cpu_wins;
    logic       issue_valid;
    logic       issue_owner;

    always_comb begin
        cpu_wins = cpu_req && (!vid_req || (run_cnt_q == RUN_LIMIT));
        cpu_gnt  = reset_n && cpu_wins;
        vid_gnt  = reset_n && vid_req && !cpu_wins;

        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (cpu_gnt) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
        end else if (vid_gnt) begin
            ram_addr = vid_addr;
        end

        // The run only counts video wins that actually kept a CPU waiting.
        run_cnt_d = run_cnt_q;
        if (!cpu_req || cpu_gnt) begin
            run_cnt_d = '0;
        end else if (vid_gnt && (run_cnt_q != RUN_LIMIT)) begin
            run_cnt_d = run_cnt_q + 4'd1;
        end

        issue_valid = vid_gnt || (cpu_gnt && !cpu_we);
        issue_owner = cpu_gnt ? OWN_CPU : OWN_VID;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end

    vram_rd_tracker #(
        .LATENCY (RAM_LATENCY)
    ) u_rd_tracker (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_valid (issue_valid),
        .issue_owner (issue_owner),
        .ram_rdata   (ram_rdata),
        .vid_rvalid  (vid_rvalid),
        .vid_rdata   (vid_rdata),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata)
    );

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a 2-cycle RAM model, an arbitration/reference-memory
// scoreboard checked every cycle, plus directed scenarios with fixed expectations.
module tb_vram_arbiter;

    localparam int MAX_RUN = 7;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vid_req = 1'b0;
    logic [14:0] vid_addr = '0;
    logic        vid_gnt, vid_rvalid;
    logic [7:0]  vid_rdata;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;

    vram_arbiter #(.MAX_VID_RUN(MAX_RUN), .RAM_LATENCY(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_gnt    (vid_gnt),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural SPRAM: address sampled at the issue edge, data two cycles later.
    logic [7:0] ram_mem [0:32767];
    logic [7:0] rd_p1 = '0;
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        rd_p1     <= ram_mem[ram_addr];
        ram_rdata <= rd_p1;
    end

    typedef struct {
        logic       own;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       sb_q [$];
    logic [7:0] ref_mem [0:32767];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         m_run = 0;
    int         cpu_wait = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic vr, input logic [14:0] va, input logic cr,
                                 input logic cw, input logic [14:0] ca, input logic [7:0] cd);
        @(posedge clk);
        #1;
        vid_req = vr; vid_addr = va;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    endtask

    // Monitor and arbitration model, evaluated mid-cycle on stable signals.
    always @(negedge clk) begin
        logic        exp_c, exp_v;
        logic [14:0] exp_addr;
        exp_t        e;
        if (!reset_n) begin
            sb_q.delete();
            m_run    = 0;
            cpu_wait = 0;
            checkOutput("reset_outputs",
                        32'({vid_gnt, cpu_gnt, ram_we, vid_rvalid, cpu_rvalid, vid_rdata, cpu_rdata}), 32'd0);
        end else begin
            if (vid_rvalid || cpu_rvalid) begin
                checkOutput("both_rvalid", 32'(vid_rvalid && cpu_rvalid), 32'd0);
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_rvalid", 32'({vid_rvalid, cpu_rvalid}), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("ret_owner", 32'(cpu_rvalid), 32'(e.own));
                    checkOutput("ret_data", 32'(cpu_rvalid ? cpu_rdata : vid_rdata), 32'(e.data));
                    checkOutput("ret_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                checkOutput("missing_rvalid", 32'd0, 32'd1);
            end

            exp_c    = cpu_req && (!vid_req || m_run == MAX_RUN);
            exp_v    = vid_req && !exp_c;
            exp_addr = exp_c ? cpu_addr : (exp_v ? vid_addr : 15'd0);
            checkOutput("grant_ram",
                        32'({vid_gnt, cpu_gnt, ram_we, ram_addr}),
                        32'({exp_v, exp_c, exp_c && cpu_we, exp_addr}));
            if (exp_c && cpu_we) checkOutput("ram_wdata", 32'(ram_wdata), 32'(cpu_wdata));

            if (exp_v) sb_q.push_back('{own: 1'b0, data: ref_mem[vid_addr], due: cyc + 2});
            if (exp_c && !cpu_we) sb_q.push_back('{own: 1'b1, data: ref_mem[cpu_addr], due: cyc + 2});
            if (exp_c && cpu_we) ref_mem[cpu_addr] = cpu_wdata;

            if (exp_c) begin
                checkOutput("cpu_wait_bound", 32'(cpu_wait + 1 > MAX_RUN + 1), 32'd0);
                cpu_wait = 0;
            end else if (cpu_req) begin
                cpu_wait++;
            end else begin
                cpu_wait = 0;
            end

            if (!cpu_req || exp_c) m_run = 0;
            else if (exp_v && m_run < MAX_RUN) m_run++;
        end
    end

    initial begin
        int  n_vid;
        logic gv, gc;
        for (int i = 0; i < 32768; i++) begin
            ram_mem[i] = 8'(i ^ (i >> 7));
        end
        for (int i = 0; i < 4; i++) ram_mem[i] = 8'hA0 + 8'(i);
        ram_mem[15'h7FFF] = 8'h3C;
        for (int i = 0; i < 32768; i++) ref_mem[i] = ram_mem[i];

        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        $display("[TB] video burst from address 0");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 15'(i), 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("vid_last_rvalid", 32'(vid_rvalid), 32'd1);
        checkOutput("vid_last_rdata", 32'(vid_rdata), 32'hA3);
        @(negedge clk);
        checkOutput("vid_rdata_hold", 32'({vid_rvalid, vid_rdata}), 32'h0A3);

        $display("[TB] cpu write then read-back");
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 15'h1234, 8'h55);
        @(negedge clk);
        checkOutput("cpu_write_we", 32'({cpu_gnt, ram_we}), 32'b11);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 15'h1234, 8'h00);
        @(negedge clk);
        checkOutput("cpu_read_we", 32'({cpu_gnt, ram_we}), 32'b10);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("cpu_readback", 32'({cpu_rvalid, cpu_rdata}), 32'h155);

        $display("[TB] starvation guard");
        applyStimulus(1'b1, 15'h0100, 1'b1, 1'b0, 15'h7FFF, 8'h00);
        n_vid = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cpu_gnt) break;
            if (vid_gnt) n_vid++;
        end
        checkOutput("vid_run_len", 32'(n_vid), 32'(MAX_RUN));
        applyStimulus(1'b1, 15'h0101, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("vid_resumes", 32'(vid_gnt), 32'd1);
        @(negedge clk);
        checkOutput("cpu_starve_data", 32'({cpu_rvalid, cpu_rdata}), 32'h13C);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);

        $display("[TB] alternating video and cpu reads");
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) applyStimulus(1'b1, 15'(i), 1'b0, 1'b0, '0, '0);
            else            applyStimulus(1'b0, '0, 1'b1, 1'b0, 15'h7FFF - 15'(i), '0);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);

        $display("[TB] reset with a read in flight");
        applyStimulus(1'b1, 15'h0005, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        vid_req = 1'b1; vid_addr = 15'h0006;
        @(negedge clk);
        checkOutput("first_grant_after_reset", 32'(vid_gnt), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);

        $display("[TB] random concurrent traffic");
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            gv = vid_gnt;
            gc = cpu_gnt;
            @(posedge clk);
            #1;
            if (!vid_req || gv || $urandom_range(0, 7) == 0) begin
                vid_req  = ($urandom_range(0, 3) != 0);
                vid_addr = 15'($urandom);
            end
            if (!cpu_req || gc) begin
                cpu_req   = ($urandom_range(0, 2) == 0);
                cpu_we    = 1'($urandom);
                cpu_addr  = ($urandom_range(0, 1) == 0) ? 15'($urandom_range(0, 15)) : 15'($urandom);
                cpu_wdata = 8'($urandom);
            end
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
